pipe_ctl_reg: RTL and testbench
===============================

# pipe_ctl_reg

Parametrised control-path pipeline register for the MIPS core, replacing the fixed per-boundary control latches (ID/EX, EX/MEM, MEM/WB) with one generic block. It carries a WIDTH-bit control bundle through DEPTH back-to-back stages with per-stage valid bits, valid/ready backpressure with bubble collapsing, and synchronous flush. Whenever a stage holds no valid entry, its control bits read as zero, so an idle or flushed slot never asserts RegWrite, MemtoReg, Jump, JumpReg or branchSel downstream.

## Interface
- WIDTH, 5: control bundle width in bits; bit assignments are defined in the shared package.
- DEPTH, 1: number of register stages, minimum 1.
- CNT_W, 16: width of the statistics counters; present only with the config macro.
- clk  input  1: clock, rising edge.
- reset  input  1: reset, synchronous, active-high.
- in_valid  input  1: upstream has a bundle.
- in_ready  output  1: block accepts the bundle this cycle.
- in_ctl  input  WIDTH: incoming control bundle.
- flush  input  1: kill all in-flight entries.
- out_valid  output  1: last stage holds a valid bundle.
- out_ready  input  1: downstream consumes this cycle.
- out_ctl  output  WIDTH: control bundle of the last stage; forced to 0 when out_valid=0.
- stall_cnt  output  CNT_W: cycles with out_valid=1 and out_ready=0 (macro only).
- flush_cnt  output  CNT_W: valid entries killed by flush (macro only).

## Operation
- Each stage i holds valid[i] and ctl[i]. Stage 0 is fed from the input; stage DEPTH-1 drives the outputs.
- Ready chain (combinational):
  - rdy[DEPTH-1] = !valid[DEPTH-1] || out_ready
  - rdy[i] = !valid[i] || rdy[i+1]
  - in_ready = rdy[0]
  - Bubbles collapse: an empty stage always accepts.
- Stage i loads from its predecessor (the input for i=0) when rdy[i]=1:
  - valid[i] <= predecessor valid
  - ctl[i] <= predecessor ctl when that valid is 1, else 0
- When rdy[i]=0 the stage holds its contents.
- Stored ctl is always 0 when valid is 0. out_ctl = valid[DEPTH-1] ? ctl[DEPTH-1] : 0.
- Flush:
  - Next cycle, every valid=0 and every ctl=0.
  - An input presented in the same cycle is dropped; in_ready still reads rdy[0] and the handshake is considered consumed.
  - Flush has priority over all movement.
- Reset: all valid=0, all ctl=0, counters=0. Reset has priority over flush.
- Counters saturate at all-ones.
  - flush_cnt adds the popcount of the valid bits at the flush edge.
  - flush_cnt does not change when the pipe is already empty.

## Timing
- Latency: an accepted bundle appears at out_ctl exactly DEPTH cycles later when no stalls occur.
- Throughput: 1 bundle per cycle sustained when out_ready=1.
- in_ready depends combinationally on out_ready through at most DEPTH gates. There is no combinational path from in_valid or in_ctl to any output.
- Reset values: out_valid=0, out_ctl=0, in_ready=1 (because all stages are empty), stall_cnt=0, flush_cnt=0.
- Full pipe with out_ready=0: in_ready=0 and every stage holds.
- Releasing out_ready frees every stage in the same cycle.
- If reset asserts mid-stream, all entries are lost by the next cycle, with no partial update.

## Configuration
- PIPE_CTL_STAT_EN defined: stall_cnt and flush_cnt ports and their counter logic exist.
- PIPE_CTL_STAT_EN undefined:
  - The ports are absent and no counter logic is generated.
  - Datapath behaviour is identical either way.

## Structure
- pipe_ctl_pkg holds:
  - Constants CTL_REGWRITE=0, CTL_MEMTOREG=1, CTL_JUMP=2, CTL_JUMPREG=3, CTL_BRANCHSEL=4, and CTL_W=5.
  - A packed struct ctl_bundle_t over those bits.
  - A default-zero constant CTL_NOP.
- Sub-module pipe_ctl_slot: one stage, holding the valid/ctl register, the rdy computation, the flush clear and the zero-gating.
- pipe_ctl_reg instantiates DEPTH slots in a generate loop, plus the optional counters.

## Test plan
- Reset with DEPTH=3: after reset, out_valid=0, out_ctl=0, in_ready=1, and the counters are 0.
- Streaming, DEPTH=3: drive in_ctl=5'h01, 5'h02, 5'h03 on consecutive cycles with out_ready=1.
  - The same values appear on out_ctl at cycles 3, 4 and 5.
  - out_ctl=0 in the gaps.
- Backpressure, DEPTH=2: fill with 5'h11 and 5'h12, then hold out_ready=0 for 4 cycles.
  - in_ready=0 and out_ctl holds 5'h11.
  - stall_cnt=4.
  - Releasing out_ready then delivers 5'h11 and 5'h12 on consecutive cycles.
- Bubble collapse, DEPTH=3: insert a single 5'h1F followed by 2 idle cycles, with out_ready=0.
  - in_ready stays 1 until all 3 stages hold valid data.
- Flush with concurrent input, DEPTH=3: two valid entries in flight, then flush=1 and in_valid=1 with 5'h0A.
  - Next cycle, out_valid=0 and all stages are empty.
  - 5'h0A never appears at the output.
  - flush_cnt=2.
- Reset and flush together while full: all stages are empty and flush_cnt=0.

Source files
------------

// File: rtl/pipe_ctl_pkg.sv
// pipe_ctl_pkg
// Shared definitions for the control-path pipeline register.
// Holds the bit positions of the MIPS control bundle, a packed struct
// view over those bits and an all-zero "no operation" bundle.
// The bundle bits are RegWrite, MemtoReg, Jump, JumpReg and branchSel.

package pipe_ctl_pkg;

    // Bit positions of each control signal inside the bundle
    localparam int CTL_REGWRITE  = 0;
    localparam int CTL_MEMTOREG  = 1;
    localparam int CTL_JUMP      = 2;
    localparam int CTL_JUMPREG   = 3;
    localparam int CTL_BRANCHSEL = 4;
    localparam int CTL_W         = 5;

    // Field order is MSB first, so each field sits at its CTL_* bit position
    typedef struct packed {
        logic branch_sel;
        logic jump_reg;
        logic jump;
        logic mem_to_reg;
        logic reg_write;
    } ctl_bundle_t;

    // Bundle seen by downstream logic for an idle or killed slot
    localparam ctl_bundle_t CTL_NOP = '0;

endpackage

// File: rtl/pipe_ctl_slot.sv
// pipe_ctl_slot
// One stage of the control-path pipeline: a valid bit plus a WIDTH-bit
// control register, the stage's ready term and the zero gating.
//
// Ports:
//   clk, reset   : clock (rising edge), synchronous active-high reset
//   flush        : clears the stage on the next edge
//   prev_valid   : valid of the predecessor (or pipeline input)
//   prev_ctl     : control bundle of the predecessor (or pipeline input)
//   next_rdy     : ready of the successor (or downstream out_ready)
//   slot_valid   : this stage holds a valid entry
//   slot_ctl     : this stage's bundle, zero whenever slot_valid is 0
//   slot_rdy     : this stage can take the predecessor's entry this cycle

module pipe_ctl_slot
    import pipe_ctl_pkg::*;
#(
    parameter int WIDTH = CTL_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             prev_valid,
    input  logic [WIDTH-1:0] prev_ctl,
    input  logic             next_rdy,
    output logic             slot_valid,
    output logic [WIDTH-1:0] slot_ctl,
    output logic             slot_rdy
);

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] ctl_q, ctl_d;

    // An empty stage always accepts, which is what collapses bubbles
    assign slot_rdy = !valid_q || next_rdy;

    always_comb begin
        valid_d = valid_q;
        ctl_d   = ctl_q;
        if (flush) begin
            valid_d = 1'b0;
            ctl_d   = '0;
        end else if (slot_rdy) begin
            // Store zero for an invalid predecessor so a bubble never carries stale bits
            valid_d = prev_valid;
            ctl_d   = prev_valid ? prev_ctl : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            ctl_q   <= '0;
        end else begin
            valid_q <= valid_d;
            ctl_q   <= ctl_d;
        end
    end

    assign slot_valid = valid_q;
    assign slot_ctl   = valid_q ? ctl_q : '0;

endmodule

// File: rtl/pipe_ctl_reg.sv
// pipe_ctl_reg
// Generic control-path pipeline register: carries a WIDTH-bit control
// bundle through DEPTH stages with valid/ready backpressure, bubble
// collapsing and synchronous flush. Idle slots always read as zero.
//
// Optional feature macro: PIPE_CTL_STAT_EN adds the CNT_W parameter and the
// saturating stall_cnt / flush_cnt statistics counters and ports.
//
// Ports:
//   clk, reset          : clock (rising edge), synchronous active-high reset
//   in_valid / in_ready : upstream handshake
//   in_ctl              : incoming control bundle
//   flush               : kill every in-flight entry on the next edge
//   out_valid/out_ready : downstream handshake
//   out_ctl             : last-stage bundle, zero when out_valid is 0
//   stall_cnt           : cycles with out_valid=1 and out_ready=0 (macro only)
//   flush_cnt           : valid entries killed by flush (macro only)

module pipe_ctl_reg
    import pipe_ctl_pkg::*;
#(
    parameter int WIDTH = CTL_W,
    parameter int DEPTH = 1
`ifdef PIPE_CTL_STAT_EN
    ,
    parameter int CNT_W = 16
`endif
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_ctl,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_ctl
`ifdef PIPE_CTL_STAT_EN
    ,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
`endif
);

    // Unpacked per-stage wires keep each ready term separate in the chain
    logic             stage_valid [DEPTH];
    logic [WIDTH-1:0] stage_ctl   [DEPTH];
    logic             stage_rdy   [DEPTH];

    for (genvar i = 0; i < DEPTH; i++) begin : g_slot
        logic             prev_valid;
        logic [WIDTH-1:0] prev_ctl;
        logic             next_rdy;

        if (i == 0) begin : g_first
            assign prev_valid = in_valid;
            assign prev_ctl   = in_ctl;
        end else begin : g_mid
            assign prev_valid = stage_valid[i-1];
            assign prev_ctl   = stage_ctl[i-1];
        end

        if (i == DEPTH - 1) begin : g_last
            assign next_rdy = out_ready;
        end else begin : g_inner
            assign next_rdy = stage_rdy[i+1];
        end

        pipe_ctl_slot #(
            .WIDTH(WIDTH)
        ) u_slot (
            .clk        (clk),
            .reset      (reset),
            .flush      (flush),
            .prev_valid (prev_valid),
            .prev_ctl   (prev_ctl),
            .next_rdy   (next_rdy),
            .slot_valid (stage_valid[i]),
            .slot_ctl   (stage_ctl[i]),
            .slot_rdy   (stage_rdy[i])
        );
    end

    // During a flush the input handshake still completes; the entry is simply dropped
    assign in_ready  = stage_rdy[0];
    assign out_valid = stage_valid[DEPTH-1];
    assign out_ctl   = stage_ctl[DEPTH-1];

`ifdef PIPE_CTL_STAT_EN
    localparam int LIVE_W = $clog2(DEPTH + 1);

    logic [LIVE_W-1:0] live_cnt;
    logic [CNT_W:0]    flush_sum;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

    // Number of valid entries that a flush this cycle would kill
    always_comb begin
        live_cnt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            live_cnt = live_cnt + LIVE_W'(stage_valid[i]);
        end
    end

    // One spare bit catches the carry so the flush count can saturate
    assign flush_sum = {1'b0, flush_cnt_q} + (CNT_W + 1)'(live_cnt);

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stage_valid[DEPTH-1] && !out_ready && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        flush_cnt_d = flush_cnt_q;
        if (flush) begin
            flush_cnt_d = flush_sum[CNT_W] ? '1 : flush_sum[CNT_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_ctl_reg.sv
// tb_pipe_ctl_reg
// Drives three pipe_ctl_reg instances (DEPTH 1, 2 and 3) from one shared
// stimulus stream. Every cycle each instance is compared with a queue-style
// reference model; table vectors and hand sequences add fixed expectations.

module tb_pipe_ctl_reg;

    logic       clk;
    logic       reset;
    logic       in_valid;
    logic [4:0] in_ctl;
    logic       flush;
    logic       out_ready;

    logic        rdy_o [3];
    logic        ov_o  [3];
    logic [4:0]  oc_o  [3];
    logic [15:0] sc_o  [3];
    logic [15:0] fc_o  [3];

    int n_checks;
    int n_fail;
    int cyc;
    bit model_known;

    // Reference model: per-instance slot occupancy, index 0 nearest the input
    logic       mv [3][3];
    logic [4:0] mc [3][3];
    int         ms [3];
    int         mf [3];

    pipe_ctl_reg #(.WIDTH(5), .DEPTH(1)) u_dut1 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy_o[0]),
        .in_ctl(in_ctl), .flush(flush), .out_valid(ov_o[0]),
        .out_ready(out_ready), .out_ctl(oc_o[0])
`ifdef PIPE_CTL_STAT_EN
        , .stall_cnt(sc_o[0]), .flush_cnt(fc_o[0])
`endif
    );

    pipe_ctl_reg #(.WIDTH(5), .DEPTH(2)) u_dut2 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy_o[1]),
        .in_ctl(in_ctl), .flush(flush), .out_valid(ov_o[1]),
        .out_ready(out_ready), .out_ctl(oc_o[1])
`ifdef PIPE_CTL_STAT_EN
        , .stall_cnt(sc_o[1]), .flush_cnt(fc_o[1])
`endif
    );

    pipe_ctl_reg #(.WIDTH(5), .DEPTH(3)) u_dut3 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy_o[2]),
        .in_ctl(in_ctl), .flush(flush), .out_valid(ov_o[2]),
        .out_ready(out_ready), .out_ctl(oc_o[2])
`ifdef PIPE_CTL_STAT_EN
        , .stall_cnt(sc_o[2]), .flush_cnt(fc_o[2])
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Closed form of the ready chain: a stage may move if any slot at or after it is empty
    function automatic logic modelReady(input int k, input int i);
        logic r;
        r = out_ready;
        for (int j = i; j <= k; j++) begin
            if (!mv[k][j]) r = 1'b1;
        end
        return r;
    endfunction

    task automatic modelStep();
        for (int k = 0; k < 3; k++) begin
            logic r [3];
            int   d;
            int   live;
            d = k + 1;
            for (int i = 0; i < d; i++) r[i] = modelReady(k, i);
            if (reset) begin
                for (int i = 0; i < 3; i++) begin
                    mv[k][i] = 1'b0;
                    mc[k][i] = 5'h00;
                end
                ms[k] = 0;
                mf[k] = 0;
            end else begin
                if (mv[k][d-1] && !out_ready && ms[k] < 65535) ms[k]++;
                if (flush) begin
                    live = 0;
                    for (int i = 0; i < d; i++) if (mv[k][i]) live++;
                    mf[k] = (mf[k] + live > 65535) ? 65535 : mf[k] + live;
                    for (int i = 0; i < 3; i++) begin
                        mv[k][i] = 1'b0;
                        mc[k][i] = 5'h00;
                    end
                end else begin
                    for (int i = d - 1; i >= 0; i--) begin
                        if (r[i]) begin
                            if (i == 0) begin
                                mv[k][0] = in_valid;
                                mc[k][0] = in_valid ? in_ctl : 5'h00;
                            end else begin
                                mv[k][i] = mv[k][i-1];
                                mc[k][i] = mc[k][i-1];
                            end
                        end
                    end
                end
            end
        end
    endtask

    task automatic checkOutput(input string name, input int k,
                               input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s depth%0d cycle %0d: got %h, expected %h",
                     name, k + 1, cyc, act, exp);
        end
    endtask

    // Set inputs just after an edge and settle to the falling edge for sampling
    task automatic applyStimulus(input logic v, input logic [4:0] c,
                                 input logic ordy, input logic fl, input logic rs);
        in_valid  = v;
        in_ctl    = c;
        out_ready = ordy;
        flush     = fl;
        reset     = rs;
        @(negedge clk);
    endtask

    // Compare all instances with the model, then take the clock edge
    task automatic advance();
        if (model_known) begin
            for (int k = 0; k < 3; k++) begin
                checkOutput("model_out_valid", k, 16'(ov_o[k]), 16'(mv[k][k]));
                checkOutput("model_out_ctl", k, 16'(oc_o[k]),
                            16'(mv[k][k] ? mc[k][k] : 5'h00));
                checkOutput("model_in_ready", k, 16'(rdy_o[k]), 16'(modelReady(k, 0)));
`ifdef PIPE_CTL_STAT_EN
                checkOutput("model_stall_cnt", k, sc_o[k], 16'(ms[k]));
                checkOutput("model_flush_cnt", k, fc_o[k], 16'(mf[k]));
`endif
            end
        end
        @(posedge clk);
        modelStep();
        if (reset) model_known = 1'b1;
        cyc++;
        #1;
    endtask

    task automatic doReset();
        applyStimulus(1'b0, 5'h00, 1'b1, 1'b0, 1'b1);
        advance();
    endtask

    typedef struct {
        logic       v;
        logic [4:0] c;
        logic       ordy;
        logic       ev;
        logic [4:0] ec;
        logic       erdy;
    } vec_t;

    vec_t vecs [14];

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        cyc         = 0;
        model_known = 1'b0;
        for (int k = 0; k < 3; k++) begin
            ms[k] = 0;
            mf[k] = 0;
            for (int i = 0; i < 3; i++) begin
                mv[k][i] = 1'b0;
                mc[k][i] = 5'h00;
            end
        end

        // Streaming on DEPTH 3: outputs appear three cycles after acceptance
        vecs[0]  = '{1'b1, 5'h01, 1'b1, 1'b0, 5'h00, 1'b1};
        vecs[1]  = '{1'b1, 5'h02, 1'b1, 1'b0, 5'h00, 1'b1};
        vecs[2]  = '{1'b1, 5'h03, 1'b1, 1'b0, 5'h00, 1'b1};
        vecs[3]  = '{1'b0, 5'h00, 1'b1, 1'b1, 5'h01, 1'b1};
        vecs[4]  = '{1'b0, 5'h00, 1'b1, 1'b1, 5'h02, 1'b1};
        vecs[5]  = '{1'b0, 5'h00, 1'b1, 1'b1, 5'h03, 1'b1};
        vecs[6]  = '{1'b0, 5'h00, 1'b1, 1'b0, 5'h00, 1'b1};
        vecs[7]  = '{1'b1, 5'h04, 1'b1, 1'b0, 5'h00, 1'b1};
        vecs[8]  = '{1'b0, 5'h1F, 1'b1, 1'b0, 5'h00, 1'b1};
        vecs[9]  = '{1'b1, 5'h05, 1'b1, 1'b0, 5'h00, 1'b1};
        vecs[10] = '{1'b0, 5'h00, 1'b1, 1'b1, 5'h04, 1'b1};
        vecs[11] = '{1'b0, 5'h00, 1'b1, 1'b0, 5'h00, 1'b1};
        vecs[12] = '{1'b0, 5'h00, 1'b1, 1'b1, 5'h05, 1'b1};
        vecs[13] = '{1'b0, 5'h00, 1'b1, 1'b0, 5'h00, 1'b1};

        applyStimulus(1'b0, 5'h00, 1'b1, 1'b0, 1'b1);
        advance();
        advance();

        // Reset state
        applyStimulus(1'b0, 5'h00, 1'b1, 1'b0, 1'b0);
        checkOutput("reset_out_valid", 2, 16'(ov_o[2]), 16'h0);
        checkOutput("reset_out_ctl", 2, 16'(oc_o[2]), 16'h0);
        checkOutput("reset_in_ready", 2, 16'(rdy_o[2]), 16'h1);
`ifdef PIPE_CTL_STAT_EN
        checkOutput("reset_stall_cnt", 2, sc_o[2], 16'h0);
        checkOutput("reset_flush_cnt", 2, fc_o[2], 16'h0);
`endif
        advance();

        for (int n = 0; n < 14; n++) begin
            applyStimulus(vecs[n].v, vecs[n].c, vecs[n].ordy, 1'b0, 1'b0);
            checkOutput("vec_out_valid", 2, 16'(ov_o[2]), 16'(vecs[n].ev));
            checkOutput("vec_out_ctl", 2, 16'(oc_o[2]), 16'(vecs[n].ec));
            checkOutput("vec_in_ready", 2, 16'(rdy_o[2]), 16'(vecs[n].erdy));
            advance();
        end

        // Backpressure on DEPTH 2
        doReset();
        applyStimulus(1'b1, 5'h11, 1'b0, 1'b0, 1'b0);
        advance();
        applyStimulus(1'b1, 5'h12, 1'b0, 1'b0, 1'b0);
        advance();
        for (int n = 0; n < 4; n++) begin
            applyStimulus(1'b0, 5'h00, 1'b0, 1'b0, 1'b0);
            checkOutput("bp_in_ready", 1, 16'(rdy_o[1]), 16'h0);
            checkOutput("bp_out_ctl_hold", 1, 16'(oc_o[1]), 16'h11);
            advance();
        end
        applyStimulus(1'b0, 5'h00, 1'b1, 1'b0, 1'b0);
        checkOutput("bp_release_first", 1, 16'(oc_o[1]), 16'h11);
        checkOutput("bp_release_in_ready", 1, 16'(rdy_o[1]), 16'h1);
`ifdef PIPE_CTL_STAT_EN
        checkOutput("bp_stall_cnt", 1, sc_o[1], 16'd4);
`endif
        advance();
        applyStimulus(1'b0, 5'h00, 1'b1, 1'b0, 1'b0);
        checkOutput("bp_release_second", 1, 16'(oc_o[1]), 16'h12);
        advance();
        applyStimulus(1'b0, 5'h00, 1'b1, 1'b0, 1'b0);
        checkOutput("bp_drained", 1, 16'(ov_o[1]), 16'h0);
        advance();

        // Bubble collapse on DEPTH 3 with downstream stalled
        doReset();
        applyStimulus(1'b1, 5'h1F, 1'b0, 1'b0, 1'b0);
        checkOutput("bubble_rdy_c0", 2, 16'(rdy_o[2]), 16'h1);
        advance();
        for (int n = 0; n < 2; n++) begin
            applyStimulus(1'b0, 5'h00, 1'b0, 1'b0, 1'b0);
            checkOutput("bubble_rdy_idle", 2, 16'(rdy_o[2]), 16'h1);
            advance();
        end
        applyStimulus(1'b1, 5'h01, 1'b0, 1'b0, 1'b0);
        checkOutput("bubble_rdy_c3", 2, 16'(rdy_o[2]), 16'h1);
        checkOutput("bubble_head_ctl", 2, 16'(oc_o[2]), 16'h1F);
        advance();
        applyStimulus(1'b1, 5'h02, 1'b0, 1'b0, 1'b0);
        checkOutput("bubble_rdy_c4", 2, 16'(rdy_o[2]), 16'h1);
        advance();
        applyStimulus(1'b0, 5'h00, 1'b0, 1'b0, 1'b0);
        checkOutput("bubble_rdy_full", 2, 16'(rdy_o[2]), 16'h0);
        advance();

        // Flush with a concurrent input on DEPTH 3
        doReset();
        applyStimulus(1'b1, 5'h05, 1'b1, 1'b0, 1'b0);
        advance();
        applyStimulus(1'b1, 5'h06, 1'b1, 1'b0, 1'b0);
        advance();
        applyStimulus(1'b1, 5'h0A, 1'b1, 1'b1, 1'b0);
        checkOutput("flush_in_ready", 2, 16'(rdy_o[2]), 16'h1);
        advance();
        applyStimulus(1'b0, 5'h00, 1'b1, 1'b0, 1'b0);
        checkOutput("flush_empty_rdy", 2, 16'(rdy_o[2]), 16'h1);
`ifdef PIPE_CTL_STAT_EN
        checkOutput("flush_cnt", 2, fc_o[2], 16'd2);
`endif
        for (int n = 0; n < 4; n++) begin
            if (n > 0) applyStimulus(1'b0, 5'h00, 1'b1, 1'b0, 1'b0);
            checkOutput("flush_out_valid", 2, 16'(ov_o[2]), 16'h0);
            checkOutput("flush_out_ctl", 2, 16'(oc_o[2]), 16'h0);
            advance();
        end

        // Reset and flush together on a full pipe
        doReset();
        applyStimulus(1'b1, 5'h07, 1'b0, 1'b0, 1'b0);
        advance();
        applyStimulus(1'b1, 5'h08, 1'b0, 1'b0, 1'b0);
        advance();
        applyStimulus(1'b1, 5'h09, 1'b0, 1'b0, 1'b0);
        advance();
        applyStimulus(1'b0, 5'h00, 1'b0, 1'b1, 1'b1);
        checkOutput("rf_full_rdy", 2, 16'(rdy_o[2]), 16'h0);
        advance();
        applyStimulus(1'b0, 5'h00, 1'b1, 1'b0, 1'b0);
        checkOutput("rf_out_valid", 2, 16'(ov_o[2]), 16'h0);
        checkOutput("rf_in_ready", 2, 16'(rdy_o[2]), 16'h1);
`ifdef PIPE_CTL_STAT_EN
        checkOutput("rf_flush_cnt", 2, fc_o[2], 16'h0);
`endif
        advance();

        // Randomized traffic against the reference model
        for (int n = 0; n < 400; n++) begin
            applyStimulus(1'($urandom_range(0, 1)),
                          5'($urandom),
                          ($urandom_range(0, 9) < 7),
                          ($urandom_range(0, 15) == 0),
                          ($urandom_range(0, 49) == 0));
            advance();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
